// File: rtl/eth_fc_pkg.sv
// rtl/eth_fc_pkg.sv - shared types and constants for PAUSE flow control
package eth_fc_pkg;

    localparam int FC_QUANTA_W = 16;
    localparam logic [FC_QUANTA_W-1:0] FC_RESUME_VAL = 16'h0000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_PAUSE  = 2'd1,
        PAUSED      = 2'd2,
        SEND_RESUME = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_refresh_timer.sv
// rtl/fc_refresh_timer.sv - counts cycles spent paused, flags refresh point
module fc_refresh_timer #(
    parameter int REFRESH_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pause_flow_ctrl.sv
// rtl/pause_flow_ctrl.sv - hysteresis PAUSE/resume request scheduler for the RX FIFO
module pause_flow_ctrl
    import eth_fc_pkg::*;
#(
    parameter int                     LVL_W          = 10,
    parameter int                     HI_WM          = 768,
    parameter int                     LO_WM          = 256,
    parameter logic [FC_QUANTA_W-1:0] PAUSE_QUANTA   = 16'h00FF,
    parameter int                     REFRESH_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LVL_W-1:0]       fifo_level,
    input  logic [47:0]            src_addr,
    output logic                   tx_pause_req,
    output logic [FC_QUANTA_W-1:0] tx_pause_val,
    output logic [47:0]            tx_pause_source_addr,
    input  logic                   tx_pause_ack,
    output logic                   paused,
    output logic [15:0]            pause_count
);

    if (LO_WM >= HI_WM) begin : g_wm_order_check
        $error("pause_flow_ctrl: LO_WM must be below HI_WM");
    end
    if (REFRESH_CYCLES < 2) begin : g_refresh_check
        $error("pause_flow_ctrl: REFRESH_CYCLES must be at least 2");
    end

    fc_state_t              state_q, state_d;
    logic                   req_q, req_d;
    logic [FC_QUANTA_W-1:0] val_q, val_d;
    logic [47:0]            addr_q, addr_d;
    logic                   paused_q, paused_d;
    logic [15:0]            count_q, count_d;
    logic                   refresh_due;

    wire lvl_high = (fifo_level >= LVL_W'(HI_WM));
    wire lvl_low  = (fifo_level <= LVL_W'(LO_WM));

    // Timer sits at zero outside PAUSED, so every entry starts a fresh period.
    fc_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != PAUSED),
        .run    (state_q == PAUSED),
        .expired(refresh_due)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        val_d    = val_q;
        addr_d   = addr_q;
        paused_d = paused_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (enable && lvl_high) begin
                    state_d = SEND_PAUSE;
                    req_d   = 1'b1;
                    val_d   = PAUSE_QUANTA;
                    addr_d  = src_addr;
                end
            end
            SEND_PAUSE: begin
                if (tx_pause_ack) begin
                    state_d  = PAUSED;
                    req_d    = 1'b0;
                    paused_d = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            PAUSED: begin
                // Resume wins over a refresh that falls due on the same cycle.
                if (lvl_low || !enable) begin
                    state_d = SEND_RESUME;
                    req_d   = 1'b1;
                    val_d   = FC_RESUME_VAL;
                    addr_d  = src_addr;
                end else if (refresh_due) begin
                    state_d = SEND_PAUSE;
                    req_d   = 1'b1;
                    val_d   = PAUSE_QUANTA;
                    addr_d  = src_addr;
                end
            end
            SEND_RESUME: begin
                if (tx_pause_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    paused_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            val_q    <= '0;
            addr_q   <= '0;
            paused_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            val_q    <= val_d;
            addr_q   <= addr_d;
            paused_q <= paused_d;
            count_q  <= count_d;
        end
    end

    assign tx_pause_req         = req_q;
    assign tx_pause_val         = val_q;
    assign tx_pause_source_addr = addr_q;
    assign paused               = paused_q;
    assign pause_count          = count_q;

endmodule
